// File: rtl/operand_issue_stage.sv
// Operand issue stage: reads the register file, forwards same-cycle writeback,
// blocks on RAW/WAW hazards via a per-register pending scoreboard, and registers operands for execute.
module operand_issue_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                         CLK,
  input  logic                         RST_N,

  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OP_WIDTH-1:0]          in_op,
  input  logic [ADDR_WIDTH-1:0]        in_rs0,
  input  logic [ADDR_WIDTH-1:0]        in_rs1,
  input  logic [ADDR_WIDTH-1:0]        in_rd,
  input  logic                         in_regWrite,
  input  logic [DATA_WIDTH-1:0]        in_imm,

  output logic [ADDR_WIDTH-1:0]        rf_rs0,
  output logic [ADDR_WIDTH-1:0]        rf_rs1,
  input  logic [DATA_WIDTH-1:0]        rf_A,
  input  logic [DATA_WIDTH-1:0]        rf_B,

  input  logic                         wb_regWrite,
  input  logic [ADDR_WIDTH-1:0]        wb_rd,
  input  logic [DATA_WIDTH-1:0]        wb_data,

  input  logic                         flush,

  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OP_WIDTH-1:0]          out_op,
  output logic [ADDR_WIDTH-1:0]        out_rd,
  output logic                         out_regWrite,
  output logic [DATA_WIDTH-1:0]        out_imm,
  output logic [DATA_WIDTH-1:0]        out_A,
  output logic [DATA_WIDTH-1:0]        out_B,

  output logic [(2**ADDR_WIDTH)-1:0]   dbg_pending
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and the producer holds its payload stable
  // while valid && !ready. in_ready is combinational; out_* come from a register.

  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_next;
  logic                  wb_hit0;
  logic                  wb_hit1;
  logic                  wb_hit_rd;
  logic                  src0_busy;
  logic                  src1_busy;
  logic                  dst_busy;
  logic                  out_free;
  logic                  accept;
  logic                  drop;
  logic [DATA_WIDTH-1:0] op_a;
  logic [DATA_WIDTH-1:0] op_b;

  assign rf_rs0      = in_rs0;
  assign rf_rs1      = in_rs1;
  assign dbg_pending = pending;

  assign wb_hit0   = wb_regWrite && (wb_rd == in_rs0);
  assign wb_hit1   = wb_regWrite && (wb_rd == in_rs1);
  assign wb_hit_rd = wb_regWrite && (wb_rd == in_rd);

  // Register 0 is hardwired to zero, so it never forwards a writeback value.
  always_comb begin
    op_a = rf_A;
    if (in_rs0 == '0)
      op_a = '0;
    else if (wb_hit0)
      op_a = wb_data;
  end

  always_comb begin
    op_b = rf_B;
    if (in_rs1 == '0)
      op_b = '0;
    else if (wb_hit1)
      op_b = wb_data;
  end

  assign src0_busy = pending[in_rs0] && !wb_hit0;
  assign src1_busy = pending[in_rs1] && !wb_hit1;
  assign dst_busy  = in_regWrite && (in_rd != '0) && pending[in_rd] && !wb_hit_rd;

  assign out_free = !out_valid || out_ready;
  assign in_ready = !src0_busy && !src1_busy && !dst_busy && out_free && !flush;
  assign accept   = in_valid && in_ready;
  assign drop     = flush && out_valid;

  // Clears are applied before the set so a same-edge clear+set leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (wb_regWrite)
      pending_next[wb_rd] = 1'b0;
    if (drop && out_regWrite && (out_rd != '0))
      pending_next[out_rd] = 1'b0;
    if (accept && in_regWrite && (in_rd != '0))
      pending_next[in_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)
      pending <= '0;
    else
      pending <= pending_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_valid    <= 1'b0;
      out_op       <= '0;
      out_rd       <= '0;
      out_regWrite <= 1'b0;
      out_imm      <= '0;
      out_A        <= '0;
      out_B        <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_op       <= in_op;
      out_rd       <= in_rd;
      out_regWrite <= in_regWrite;
      out_imm      <= in_imm;
      out_A        <= op_a;
      out_B        <= op_b;
    end else if (drop || out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
// Directed bench for operand_issue_stage: transaction-level model (expected
// output queue + pending set) checked every cycle, plus literal spot checks.
module tb_operand_issue_stage;

  logic        CLK;
  logic        RST_N;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [3:0]  in_rs0;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rd;
  logic        in_regWrite;
  logic [15:0] in_imm;
  logic [3:0]  rf_rs0;
  logic [3:0]  rf_rs1;
  logic [15:0] rf_A;
  logic [15:0] rf_B;
  logic        wb_regWrite;
  logic [3:0]  wb_rd;
  logic [15:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic        out_regWrite;
  logic [15:0] out_imm;
  logic [15:0] out_A;
  logic [15:0] out_B;
  logic [15:0] dbg_pending;

  operand_issue_stage dut (
    .CLK(CLK), .RST_N(RST_N),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd),
    .in_regWrite(in_regWrite), .in_imm(in_imm),
    .rf_rs0(rf_rs0), .rf_rs1(rf_rs1), .rf_A(rf_A), .rf_B(rf_B),
    .wb_regWrite(wb_regWrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rd(out_rd), .out_regWrite(out_regWrite), .out_imm(out_imm),
    .out_A(out_A), .out_B(out_B),
    .dbg_pending(dbg_pending)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic        rw;
    logic [15:0] imm;
    logic [15:0] a;
    logic [15:0] b;
  } item_t;

  item_t exp_q[$];
  bit    busy_reg[16];
  bit    started = 0;
  int    checks  = 0;
  int    errors  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fwd(input logic [3:0] rs, input logic [15:0] rf);
    if (rs == 4'd0) return 16'h0;
    if (wb_regWrite && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  // A register is still waited on unless this cycle's writeback retires it.
  function automatic bit still_busy(input logic [3:0] r);
    return busy_reg[r] && !(wb_regWrite && wb_rd == r);
  endfunction

  function automatic bit model_ready();
    bit hazard;
    hazard = still_busy(in_rs0) || still_busy(in_rs1) ||
             (in_regWrite && in_rd != 4'd0 && still_busy(in_rd));
    return !hazard && (exp_q.size() == 0 || out_ready) && !flush;
  endfunction

  function automatic logic [15:0] model_pending();
    logic [15:0] p;
    for (int i = 0; i < 16; i++) p[i] = busy_reg[i];
    return p;
  endfunction

  always @(posedge CLK) begin
    if (!RST_N) begin
      exp_q.delete();
      for (int i = 0; i < 16; i++) busy_reg[i] = 0;
      started = 1;
    end else if (started) begin
      bit    acc;
      item_t it;
      acc = in_valid && model_ready();
      it  = '{op: in_op, rd: in_rd, rw: in_regWrite, imm: in_imm,
              a: fwd(in_rs0, rf_A), b: fwd(in_rs1, rf_B)};
      if (exp_q.size() != 0 && (flush || out_ready)) begin
        if (flush && exp_q[0].rw && exp_q[0].rd != 4'd0) busy_reg[exp_q[0].rd] = 0;
        void'(exp_q.pop_front());
      end
      if (wb_regWrite) busy_reg[wb_rd] = 0;
      if (acc) begin
        exp_q.push_back(it);
        if (in_regWrite && in_rd != 4'd0) busy_reg[in_rd] = 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      check("in_ready", in_ready, model_ready());
      check("rf_rs0", rf_rs0, in_rs0);
      check("rf_rs1", rf_rs1, in_rs1);
      check("out_valid", out_valid, exp_q.size() != 0);
      check("pending", dbg_pending, model_pending());
      if (exp_q.size() != 0) begin
        check("out_op", out_op, exp_q[0].op);
        check("out_rd", out_rd, exp_q[0].rd);
        check("out_regWrite", out_regWrite, exp_q[0].rw);
        check("out_imm", out_imm, exp_q[0].imm);
        check("out_A", out_A, exp_q[0].a);
        check("out_B", out_B, exp_q[0].b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    in_valid = 0; in_op = 0; in_rs0 = 0; in_rs1 = 0; in_rd = 0;
    in_regWrite = 0; in_imm = 0;
    wb_regWrite = 0; wb_rd = 0; wb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rs0, input logic [3:0] rs1,
                       input logic [3:0] rd, input logic rw, input logic [15:0] imm);
    in_valid = 1; in_op = op; in_rs0 = rs0; in_rs1 = rs1; in_rd = rd;
    in_regWrite = rw; in_imm = imm;
  endtask

  task automatic writeback(input logic [3:0] rd, input logic [15:0] data);
    wb_regWrite = 1; wb_rd = rd; wb_data = data;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST_N = 0; rf_A = 0; rf_B = 0;
    idle();
    step(); step();
    RST_N = 1;
    settle();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_A", out_A, 16'h0);
    check("rst_out_B", out_B, 16'h0);
    check("rst_out_imm", out_imm, 16'h0);
    check("rst_out_op_rd_rw", {out_op, out_rd, out_regWrite}, 9'h0);
    check("rst_pending", dbg_pending, 16'h0);

    // r0 sources read as zero regardless of the register file bus
    rf_A = 16'h1234; rf_B = 16'h1234;
    issue(4'd1, 4'd0, 4'd0, 4'd1, 1'b0, 16'h0055);
    settle();
    check("r0_ready", in_ready, 1'b1);
    step(); idle(); settle();
    check("r0_out_valid", out_valid, 1'b1);
    check("r0_out_A", out_A, 16'h0);
    check("r0_out_B", out_B, 16'h0);
    check("r0_out_imm", out_imm, 16'h0055);
    check("r0_pending", dbg_pending, 16'h0);
    step();

    // RAW on r3, resolved by same-cycle writeback forwarding
    issue(4'd2, 4'd0, 4'd0, 4'd3, 1'b1, 16'h0);
    step();
    rf_A = 16'h1111;
    issue(4'd3, 4'd3, 4'd0, 4'd0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("raw_stall", in_ready, 1'b0);
      check("raw_pending3", dbg_pending[3], 1'b1);
      step();
    end
    writeback(4'd3, 16'h00AB);
    settle();
    check("raw_release", in_ready, 1'b1);
    step(); idle(); settle();
    check("raw_fwd_A", out_A, 16'h00AB);
    check("raw_pending3_clr", dbg_pending[3], 1'b0);
    step();

    // three independent back-to-back, then output stall
    for (int i = 0; i < 3; i++) begin
      rf_A = 16'h0100 + 16'(i); rf_B = 16'h0200 + 16'(i);
      issue(4'(i + 4), 4'(i + 1), 4'(i + 2), 4'd0, 1'b0, 16'(i));
      settle();
      check("b2b_ready", in_ready, 1'b1);
      step();
      settle();
      check("b2b_valid", out_valid, 1'b1);
    end
    issue(4'd8, 4'd1, 4'd2, 4'd0, 1'b0, 16'h0);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      settle();
      check("hold_ready", in_ready, 1'b0);
      check("hold_A", out_A, 16'h0102);
      check("hold_B", out_B, 16'h0202);
      check("hold_op", out_op, 4'd6);
      step();
    end
    idle(); step(); step();

    // WAW on r5; clear and set on the same edge leaves r5 pending
    issue(4'd9, 4'd0, 4'd0, 4'd5, 1'b1, 16'h0011);
    step();
    issue(4'd10, 4'd0, 4'd0, 4'd5, 1'b1, 16'h0099);
    settle();
    check("waw_stall", in_ready, 1'b0);
    step(); settle();
    check("waw_stall2", in_ready, 1'b0);
    writeback(4'd5, 16'h0007);
    settle();
    check("waw_release", in_ready, 1'b1);
    step(); idle(); settle();
    check("waw_pending5", dbg_pending[5], 1'b1);
    check("waw_imm", out_imm, 16'h0099);
    writeback(4'd5, 16'h0008);
    step(); idle(); step();

    // flush of held write to r7 (issue attempted during flush is refused)
    out_ready = 0;
    issue(4'd11, 4'd0, 4'd0, 4'd7, 1'b1, 16'h0);
    step();
    idle(); out_ready = 0; settle();
    check("flush_pre_valid", out_valid, 1'b1);
    check("flush_pre_pending7", dbg_pending[7], 1'b1);
    flush = 1;
    issue(4'd12, 4'd1, 4'd1, 4'd0, 1'b0, 16'h0);
    settle();
    check("flush_no_accept", in_ready, 1'b0);
    step();
    idle(); settle();
    check("flush_valid", out_valid, 1'b0);
    check("flush_pending7", dbg_pending[7], 1'b0);
    issue(4'd13, 4'd7, 4'd7, 4'd0, 1'b0, 16'h0);
    settle();
    check("flush_r7_ready", in_ready, 1'b1);
    step(); idle(); step();

    // writeback to a clear register forwards but leaves the scoreboard alone
    rf_B = 16'h1111;
    issue(4'd14, 4'd0, 4'd9, 4'd0, 1'b0, 16'h0);
    writeback(4'd9, 16'hBEEF);
    step(); idle(); settle();
    check("wbclr_fwd_B", out_B, 16'hBEEF);
    check("wbclr_pending", dbg_pending, 16'h0);
    step();

    // reset while stalled with r2 pending and output held
    rf_A = 16'h4321;
    out_ready = 0;
    issue(4'd15, 4'd1, 4'd0, 4'd2, 1'b1, 16'h0);
    step();
    out_ready = 0;
    issue(4'd1, 4'd2, 4'd0, 4'd0, 1'b0, 16'h0);
    settle();
    check("mrst_pre_ready", in_ready, 1'b0);
    check("mrst_pre_A", out_A, 16'h4321);
    check("mrst_pre_pending2", dbg_pending[2], 1'b1);
    RST_N = 0;
    step();
    RST_N = 1; settle();
    check("mrst_valid", out_valid, 1'b0);
    check("mrst_A", out_A, 16'h0);
    check("mrst_pending", dbg_pending, 16'h0);
    check("mrst_ready", in_ready, 1'b1);
    out_ready = 1;
    step(); idle(); step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
